// File: rtl/mem_sweep_ctrl.sv
// Fill-then-read sweep controller for the memory_loop datapath.
// Checks read data against a pipelined expected value and counts mismatches.
module mem_sweep_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  invert_mode,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  wren,
    output logic [DATA_WIDTH-1:0] d1,
    output logic                  do_something,
    input  logic [DATA_WIDTH-1:0] d_loadresult,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TL    = READ_LATENCY - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST    = '1;
    localparam logic [ADDR_WIDTH:0]   ERR_MAX = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2:0]              dcnt_q, dcnt_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic                    inv_q, inv_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wren_q, wren_d;
    logic [DATA_WIDTH-1:0]   d1_q, d1_d;
    logic                    ds_q, ds_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_q, rd_d;
    logic                    pass_q, pass_d;
    logic [ADDR_WIDTH:0]     err_q, err_d;
    logic [ADDR_WIDTH-1:0]   ferr_q, ferr_d;

    logic [READ_LATENCY-1:0]                 v_q;
    logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] pa_q;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pe_q;

    logic [DATA_WIDTH-1:0] pat_cur;
    logic [DATA_WIDTH-1:0] exp_new;
    logic                  mismatch;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        seed_d  = seed_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d  = seed;
                    inv_d   = invert_mode;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = READ;
            end
            READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DRAIN;
                    dcnt_d  = 3'(READ_LATENCY - 1);
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) state_d = DONE;
                else              dcnt_d  = dcnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Drive outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        wren_d = (state_d == FILL);
        rd_d   = (state_d == READ);
        busy_d = (state_d == FILL) || (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        addr_d = (wren_d || rd_d) ? cnt_d : '0;
        d1_d   = wren_d ? seed_d + DATA_WIDTH'(cnt_d) : '0;
        ds_d   = rd_d & inv_d & cnt_d[0];
    end

    // The downstream register samples ds_d together with the RAM data for addr_q.
    assign pat_cur  = seed_q + DATA_WIDTH'(addr_q);
    assign exp_new  = ds_d ? ~pat_cur : pat_cur;
    assign mismatch = v_q[TL] && (d_loadresult != pe_q[TL]);

    always_comb begin
        err_d  = err_q;
        ferr_d = ferr_q;
        pass_d = pass_q;
        if (state_q == IDLE && start) begin
            err_d  = '0;
            ferr_d = '0;
            pass_d = 1'b0;
        end else if (mismatch) begin
            if (err_q != ERR_MAX) err_d  = err_q + 1'b1;
            if (err_q == '0)      ferr_d = pa_q[TL];
        end
        if (done_d) pass_d = (err_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            seed_q  <= '0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            d1_q    <= '0;
            ds_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            v_q     <= '0;
            pa_q    <= '0;
            pe_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            seed_q  <= seed_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            d1_q    <= d1_d;
            ds_q    <= ds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            v_q[0]  <= rd_q;
            pa_q[0] <= addr_q;
            pe_q[0] <= exp_new;
            for (int i = 1; i < READ_LATENCY; i++) begin
                v_q[i]  <= v_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign d_addr         = addr_q;
    assign wren           = wren_q;
    assign d1             = d1_q;
    assign do_something   = ds_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Bench for mem_sweep_ctrl with a behavioural memory_loop model
// that can corrupt bit 0 of selected read addresses.
module tb_mem_sweep_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] seed;
    logic          invert_mode;
    logic [AW-1:0] d_addr;
    logic          wren;
    logic [DW-1:0] d1;
    logic          do_something;
    logic [DW-1:0] d_loadresult;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_sweep_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .invert_mode(invert_mode), .d_addr(d_addr), .wren(wren), .d1(d1),
        .do_something(do_something), .d_loadresult(d_loadresult),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    // memory_loop model: registered-read RAM, then registered pass/invert stage
    logic [DW-1:0]    mem [DEPTH];
    logic [DW-1:0]    q;
    logic [AW-1:0]    qa;
    logic             qrd;
    logic [DEPTH-1:0] corrupt;

    always @(posedge clk) begin
        if (wren) mem[d_addr] <= d1;
        q            <= mem[d_addr];
        qa           <= d_addr;
        qrd          <= !wren;
        d_loadresult <= (do_something ? ~q : q)
                        ^ {{(DW-1){1'b0}}, qrd && corrupt[qa]};
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {14'b0, d_addr, wren, d1, do_something, busy, done,
                pass, err_count, first_err_addr};
    endfunction

    task automatic run_sweep(input logic [DW-1:0] s, input logic inv,
                             input int restart_at, input bit start_in_done,
                             input logic exp_pass, input logic [AW:0] exp_err,
                             input logic [AW-1:0] exp_ferr);
        int k_done, nw, bad_w, bad_ds, bad_busy, ndone;
        logic exp_busy;
        k_done = -1; nw = 0; bad_w = 0; bad_ds = 0; bad_busy = 0; ndone = 0;
        @(negedge clk);
        seed = s; invert_mode = inv; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            start = (k + 1 == restart_at) || (start_in_done && done);
            if (wren) begin
                if (d_addr != AW'(nw) || d1 != s + DW'(nw)) bad_w++;
                nw++;
            end
            if (busy && !wren && do_something != (inv & d_addr[0])) bad_ds++;
            exp_busy = (k < 2*DEPTH + RL);
            if (busy != exp_busy) bad_busy++;
            if (done) begin
                ndone++;
                if (k_done < 0) k_done = k;
                check("pass_at_done", 64'(pass), 64'(exp_pass));
            end
        end
        start = 1'b0;
        if (k_done < 0) check("done_timeout", 64'(0), 64'(1));
        // done is registered after edge k_done and seen by the following edge
        else check("done_latency", 64'(k_done + 1), 64'(1 + 2*DEPTH + RL));
        check("done_pulses", 64'(ndone), 64'(1));
        check("write_count", 64'(nw), 64'(DEPTH));
        check("write_data", 64'(bad_w), 64'(0));
        check("sel_align", 64'(bad_ds), 64'(0));
        check("busy_window", 64'(bad_busy), 64'(0));
        check("pass_held", 64'(pass), 64'(exp_pass));
        check("err_count", 64'(err_count), 64'(exp_err));
        check("first_err", 64'(first_err_addr), 64'(exp_ferr));
    endtask

    typedef struct {
        logic [DW-1:0]    seed;
        logic             inv;
        logic [DEPTH-1:0] corrupt;
        logic             exp_pass;
        logic [AW:0]      exp_err;
        logic [AW-1:0]    exp_ferr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{32'h1000_0000, 1'b0, 16'h0000, 1'b1, 5'd0,  4'd0};
        tbl[1] = '{32'hFFFF_FFF8, 1'b1, 16'h0000, 1'b1, 5'd0,  4'd0};
        tbl[2] = '{32'h1000_0000, 1'b0, 16'h0220, 1'b0, 5'd2,  4'd5};
        tbl[3] = '{32'hA5A5_0000, 1'b1, 16'h8001, 1'b0, 5'd2,  4'd0};
        tbl[4] = '{32'h0000_0000, 1'b1, 16'hFFFF, 1'b0, 5'd16, 4'd0};
        tbl[5] = '{32'h1234_5678, 1'b1, 16'h4000, 1'b0, 5'd1,  4'd14};

        reset = 1'b1; start = 1'b0; seed = '0; invert_mode = 1'b0;
        corrupt = '0;
        #2;
        check("reset_outs", all_outs(), 64'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outs", all_outs(), 64'(0));
        end

        for (int i = 0; i < 6; i++) begin
            corrupt = tbl[i].corrupt;
            run_sweep(tbl[i].seed, tbl[i].inv, -1, 1'b0,
                      tbl[i].exp_pass, tbl[i].exp_err, tbl[i].exp_ferr);
        end
        corrupt = '0;

        // stray starts mid-sweep and in the DONE cycle
        run_sweep(32'h0BAD_F00D, 1'b1, 10, 1'b1, 1'b1, 5'd0, 4'd0);
        run_sweep(32'h0000_0100, 1'b0, -1, 1'b0, 1'b1, 5'd0, 4'd0);

        // reset while reading address 7
        corrupt = 16'h0001;
        @(negedge clk);
        seed = 32'h5555_0000; invert_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int found;
            found = 0;
            for (int k = 0; k < 60 && found == 0; k++) begin
                if (busy && !wren && d_addr == 4'd7) found = 1;
                else @(negedge clk);
            end
            check("reach_read7", 64'(found), 64'(1));
        end
        #1 reset = 1'b1;
        #1 check("async_reset", all_outs(), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        begin
            int nd;
            nd = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done || busy) nd++;
            end
            check("no_done_after_rst", 64'(nd), 64'(0));
        end
        corrupt = '0;
        run_sweep(32'h5555_0000, 1'b1, -1, 1'b0, 1'b1, 5'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
